// File: rtl/bcd_sevenseg_scan_if.sv
// Bus between the BCD producer (master) and the display scanner (slave).
// The master supplies digits, the load strobe and the blanking enable;
// the slave returns the anode/cathode drive and the frame pulse.
interface bcd_sevenseg_scan_if;
    logic       load;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       blank_lz;
    logic [2:0] an;
    logic [6:0] seg;
    logic       frame;

    modport master (
        output load, hundreds, tens, ones, blank_lz,
        input  an, seg, frame
    );

    modport slave (
        input  load, hundreds, tens, ones, blank_lz,
        output an, seg, frame
    );
endinterface

// File: rtl/bcd_sevenseg_scan.sv
// Three-digit multiplexed seven-segment driver. Digits are captured on a
// load strobe into a pending buffer and copied to the displayed buffer only
// at a frame boundary, so a frame never shows a mix of old and new digits.
// Each digit slot starts with a guard interval of dark anodes to avoid
// ghosting while the cathodes change.
module bcd_sevenseg_scan #(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_sevenseg_scan_if.slave bus
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

    // Digit index values: slot 0 drives ones, 1 tens, 2 hundreds.
    localparam logic [1:0] IDX_ONES = 2'd0;
    localparam logic [1:0] IDX_TENS = 2'd1;
    localparam logic [1:0] IDX_HUNS = 2'd2;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [2:0] AN_OFF   = 3'b111;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [11:0]   pend;
    logic          pend_v;
    logic [11:0]   disp;
    logic [2:0]    an_q;
    logic [6:0]    seg_q;
    logic          frame_q;

    logic          slot_end;
    logic          boundary;
    logic [3:0]    digit;
    logic          blank_digit;
    logic [2:0]    an_d;
    logic [6:0]    seg_d;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD values show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // Slot and frame boundary detection from the current scan position.
    always_comb begin
        slot_end = (cnt == CNT_LAST);
        boundary = slot_end && (idx == IDX_HUNS);
    end

    // Next anode/cathode value: dark during the guard interval, otherwise the
    // selected digit, with live leading-zero blanking of hundreds and tens.
    always_comb begin
        // NOTE: every output gets a default before the branches so no path
        // leaves a signal unassigned, which would infer a latch.
        digit       = disp[3:0];
        blank_digit = 1'b0;
        an_d        = AN_OFF;
        seg_d       = SEG_OFF;
        case (idx)
            IDX_HUNS: begin
                digit       = disp[11:8];
                blank_digit = bus.blank_lz && (disp[11:8] == 4'd0);
            end
            IDX_TENS: begin
                digit       = disp[7:4];
                blank_digit = bus.blank_lz && (disp[11:8] == 4'd0)
                                           && (disp[7:4] == 4'd0);
            end
            default: begin
                digit       = disp[3:0];
                blank_digit = 1'b0;
            end
        endcase
        if (cnt >= CNT_GUARD) begin
            an_d  = ~(3'b001 << idx);
            seg_d = blank_digit ? SEG_OFF : decode(digit);
        end
    end

    // Scan position: cnt counts cycles within a slot, idx walks the digits.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every block
        // sees the pre-edge values regardless of evaluation order.
        if (!rst_n) begin
            cnt <= '0;
            idx <= IDX_ONES;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_HUNS) ? IDX_ONES : idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Digit buffers: load fills pend, the frame boundary commits pend to disp.
    // A load on the boundary edge commits the old pend and keeps the new one.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the digit buffers are reset too, because a reset must discard
        // both pending and displayed digits immediately.
        if (!rst_n) begin
            pend   <= '0;
            pend_v <= 1'b0;
            disp   <= '0;
        end else begin
            if (boundary && pend_v) begin
                disp <= pend;
            end
            if (bus.load) begin
                pend   <= {bus.hundreds, bus.tens, bus.ones};
                pend_v <= 1'b1;
            end else if (boundary) begin
                pend_v <= 1'b0;
            end
        end
    end

    // Registered outputs, one cycle behind the scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            frame_q <= 1'b0;
        end else begin
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= boundary;
        end
    end

    assign bus.an    = an_q;
    assign bus.seg   = seg_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Bench for bcd_sevenseg_scan with SCAN_DIV=8, GUARD=2. A reference model
// predicts the output after every clock edge from the edge count since reset
// and pushes it into a queue; a monitor pops and compares on the falling edge.
module tb_bcd_sevenseg_scan;

    localparam int SD    = 8;
    localparam int G     = 2;
    localparam int FRAME = 3 * SD;

    typedef struct packed {
        logic       frame;
        logic [2:0] an;
        logic [6:0] seg;
    } exp_t;

    localparam exp_t RESET_EXP = {1'b0, 3'b111, 7'h7F};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bcd_sevenseg_scan_if bus();

    bcd_sevenseg_scan #(.SCAN_DIV(SD), .GUARD(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Reference model state: edges since reset, displayed/pending digits.
    int         m_n = 0;
    logic [3:0] m_disp [3];
    logic [3:0] m_pend [3];
    logic       m_pv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        return tbl[d];
    endfunction

    // Model: position in the scan is m_n; slot and offset follow from division.
    always @(posedge clk or negedge rst_n) begin : model
        int   slot;
        int   off;
        logic blank;
        exp_t e;
        if (!rst_n) begin
            m_n  = 0;
            m_pv = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_disp[i] = 4'd0;
                m_pend[i] = 4'd0;
            end
            exp_q.delete();
            exp_q.push_back(RESET_EXP);
        end else begin
            slot  = (m_n / SD) % 3;
            off   = m_n % SD;
            blank = 1'b0;
            if (bus.blank_lz) begin
                if (slot == 2) blank = (m_disp[2] == 4'd0);
                if (slot == 1) blank = (m_disp[2] == 4'd0) && (m_disp[1] == 4'd0);
            end
            e.frame = ((m_n % FRAME) == FRAME - 1);
            if (off < G) begin
                e.an  = 3'b111;
                e.seg = 7'h7F;
            end else begin
                e.an  = 3'b111;
                e.an[slot] = 1'b0;
                e.seg = blank ? 7'h7F : seg_of(m_disp[slot]);
            end
            exp_q.push_back(e);
            if (e.frame && m_pv) begin
                for (int i = 0; i < 3; i++) m_disp[i] = m_pend[i];
                m_pv = 1'b0;
            end
            if (bus.load) begin
                m_pend[0] = bus.ones;
                m_pend[1] = bus.tens;
                m_pend[2] = bus.hundreds;
                m_pv      = 1'b1;
            end
            m_n++;
        end
    end

    // Monitor: compare DUT outputs with the oldest prediction.
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.frame, bus.an, bus.seg};
            check($sformatf("scan_out edge%0d", m_n), 32'(a), 32'(e));
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Wait until the next edge to be sampled sits at the given frame position.
    task automatic goto_pos(input int pos);
        int budget;
        budget = 0;
        while ((m_n % FRAME) != pos && budget < 4 * FRAME) begin
            step(1);
            budget++;
        end
        check("goto_pos", 32'(m_n % FRAME), 32'(pos));
    endtask

    task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        bus.load     = 1'b1;
        bus.hundreds = h;
        bus.tens     = t;
        bus.ones     = o;
        step(1);
        bus.load     = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, " an"},    32'(bus.an),    32'(3'b111));
        check({tag, " seg"},   32'(bus.seg),   32'(7'h7F));
        check({tag, " frame"}, 32'(bus.frame), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.load     = 1'b0;
        bus.hundreds = 4'd0;
        bus.tens     = 4'd0;
        bus.ones     = 4'd0;
        bus.blank_lz = 1'b0;

        // Reset, release, then an asynchronous reset in mid-slot.
        step(3);
        rst_n = 1'b1;
        step(13);
        async_reset_check("rst_mid_slot");
        step(2 * FRAME);

        // Load 1,2,3 during slot 0; shown from the following frame on.
        goto_pos(2);
        do_load(4'd1, 4'd2, 4'd3);
        step(2 * FRAME);

        // Leading-zero blanking.
        bus.blank_lz = 1'b1;
        goto_pos(3);
        do_load(4'd0, 4'd0, 4'd7);
        step(2 * FRAME);
        do_load(4'd0, 4'd5, 4'd0);
        step(2 * FRAME);

        // Invalid hundreds digit is never treated as zero.
        do_load(4'hA, 4'd0, 4'd4);
        step(2 * FRAME);

        // Load mid-frame, then a second load on the boundary edge.
        bus.blank_lz = 1'b0;
        goto_pos(10);
        do_load(4'd1, 4'd1, 4'd1);
        goto_pos(FRAME - 1);
        do_load(4'd2, 4'd2, 4'd2);
        step(3 * FRAME);

        // Reset while 9,9,9 is displayed; a later load commits at edge 24.
        do_load(4'd9, 4'd9, 4'd9);
        step(2 * FRAME);
        goto_pos(11);
        async_reset_check("rst_in_slot1");
        step(5);
        do_load(4'd3, 4'd4, 4'd5);
        step(2 * FRAME);

        // Randomized loads, blanking and timing.
        for (int i = 0; i < 40; i++) begin
            bus.blank_lz = 1'($urandom_range(0, 1));
            step($urandom_range(1, 30));
            do_load($urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(0, 15)),
                    $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)));
        end
        step(2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
